monpro_operand_feeder: RTL and testbench

Upstream operand sequencer for the 4096-bit Montgomery product core (MonPro). It holds two 4096-bit operands, x and y, as 32 × 128-bit words written by the host or controller. On command it drives MonPro's `start`/`inp` pins with the exact streaming protocol MonPro requires: a start pulse, 32 x words, one zero gap cycle, 32 y words, then zero. A squaring mode streams x as both operands, as modular exponentiation needs.

---
 rtl/monpro_operand_feeder_pkg.sv | 31 +++
 rtl/monpro_operand_feeder_if.sv | 30 +++
 rtl/monpro_operand_feeder_operand_buffer.sv | 27 ++
 rtl/monpro_operand_feeder.sv | 124 ++++++++++++
 tb/tb_monpro_operand_feeder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/monpro_operand_feeder_pkg.sv
// Shared constants and types for the MonPro operand feeder: widths, FSM
// encodings and the packed control-state record.
package monpro_operand_feeder_pkg;

  localparam int FEED_DATA_WIDTH = 128;
  localparam int FEED_NUM_WORDS  = 32;
  localparam int FEED_CNT_W      = 5;

  // Encodings kept as plain 3-bit constants so they match the legacy header.
  localparam logic [2:0] FEED_IDLE   = 3'd0;
  localparam logic [2:0] FEED_START  = 3'd1;
  localparam logic [2:0] FEED_SEND_X = 3'd2;
  localparam logic [2:0] FEED_GAP    = 3'd3;
  localparam logic [2:0] FEED_SEND_Y = 3'd4;
  localparam logic [2:0] FEED_FIN    = 3'd5;

  typedef logic [FEED_CNT_W-1:0] feed_cnt_t;

  typedef struct packed {
    logic [2:0] state;
    feed_cnt_t  cnt;
    logic       sq;
  } feed_ctl_t;

  localparam feed_ctl_t FEED_CTL_RESET = '{state: FEED_IDLE, cnt: '0, sq: 1'b0};

  function automatic logic feed_is_data(input logic [2:0] state);
    return (state == FEED_SEND_X) || (state == FEED_SEND_Y);
  endfunction

endpackage

// File: rtl/monpro_operand_feeder_if.sv
// Host/controller-facing bus of the operand feeder: buffer write port,
// launch handshake and the MonPro start/inp drive.
interface monpro_operand_feeder_if
  import monpro_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = FEED_DATA_WIDTH
);

  logic                  wr_en;
  logic                  wr_sel;
  logic [FEED_CNT_W-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  go;
  logic                  square;
  logic                  ready;
  logic                  done;
  logic                  mp_start;
  logic [DATA_WIDTH-1:0] mp_inp;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, go, square,
    input  ready, done, mp_start, mp_inp
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, go, square,
    output ready, done, mp_start, mp_inp
  );

endinterface

// File: rtl/monpro_operand_feeder_operand_buffer.sv
// One operand held as NUM_WORDS words: synchronous write, combinational read.
module operand_buffer
  import monpro_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = FEED_DATA_WIDTH,
  parameter int NUM_WORDS  = FEED_NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  we,
  input  feed_cnt_t             waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  feed_cnt_t             raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents deliberately survive reset so an aborted stream can be relaunched.
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/monpro_operand_feeder.sv
// Streams start pulse, x words, a zero gap and y (or x when squaring) words
// into MonPro's start/inp pins, with every output registered.
module monpro_operand_feeder
  import monpro_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = FEED_DATA_WIDTH,
  parameter int NUM_WORDS  = FEED_NUM_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
  monpro_operand_feeder_if.slave  bus
);

  localparam feed_cnt_t LAST = feed_cnt_t'(NUM_WORDS - 1);

  feed_ctl_t             ctl_p0;
  feed_ctl_t             ctl_p1;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] x_rd;
  logic [DATA_WIDTH-1:0] y_rd;
  logic [DATA_WIDTH-1:0] inp_p0;
  logic [DATA_WIDTH-1:0] inp_p1;
  logic                  start_p1;
  logic                  done_p1;
  logic                  ready_p1;

  // Buffers are writable only while idle, so a running stream sees stable data.
  assign wr_ok = bus.wr_en && (ctl_p1.state == FEED_IDLE);

  operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_xbuf (
    .clk   (clk),
    .we    (wr_ok && !bus.wr_sel),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (ctl_p0.cnt),
    .rdata (x_rd)
  );

  operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_ybuf (
    .clk   (clk),
    .we    (wr_ok && bus.wr_sel),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (ctl_p0.cnt),
    .rdata (y_rd)
  );

  // p0: next control state; outputs are decoded from it so they register
  // in the same cycle the state is entered.
  always_comb begin
    ctl_p0 = ctl_p1;
    case (ctl_p1.state)
      FEED_IDLE: begin
        if (bus.go) begin
          ctl_p0.state = FEED_START;
          ctl_p0.sq    = bus.square;
        end
      end
      FEED_START: begin
        ctl_p0.state = FEED_SEND_X;
        ctl_p0.cnt   = '0;
      end
      FEED_SEND_X: begin
        ctl_p0.cnt = ctl_p1.cnt + 1'b1;
        if (ctl_p1.cnt == LAST) begin
          ctl_p0.state = FEED_GAP;
        end
      end
      FEED_GAP: begin
        ctl_p0.state = FEED_SEND_Y;
        ctl_p0.cnt   = '0;
      end
      FEED_SEND_Y: begin
        ctl_p0.cnt = ctl_p1.cnt + 1'b1;
        if (ctl_p1.cnt == LAST) begin
          ctl_p0.state = FEED_FIN;
        end
      end
      FEED_FIN: begin
        ctl_p0.state = FEED_IDLE;
        ctl_p0.cnt   = '0;
      end
      default: begin
        ctl_p0 = FEED_CTL_RESET;
      end
    endcase
  end

  always_comb begin
    inp_p0 = '0;
    if (feed_is_data(ctl_p0.state)) begin
      inp_p0 = (ctl_p0.state == FEED_SEND_Y && !ctl_p0.sq) ? y_rd : x_rd;
    end
  end

  // p1: registered control and MonPro drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_p1   <= FEED_CTL_RESET;
      start_p1 <= 1'b0;
      done_p1  <= 1'b0;
      ready_p1 <= 1'b1;
      inp_p1   <= '0;
    end else begin
      ctl_p1   <= ctl_p0;
      start_p1 <= (ctl_p0.state == FEED_START);
      done_p1  <= (ctl_p0.state == FEED_FIN);
      ready_p1 <= (ctl_p0.state == FEED_IDLE);
      inp_p1   <= inp_p0;
    end
  end

  assign bus.mp_start = start_p1;
  assign bus.done     = done_p1;
  assign bus.ready    = ready_p1;
  assign bus.mp_inp   = inp_p1;

endmodule

// File: tb/tb_monpro_operand_feeder.sv
// Directed bench for monpro_operand_feeder: cycle-exact stream checks with
// immediate assertions at every sample point.
module tb_monpro_operand_feeder;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [127:0] exp_x [32];
  logic [127:0] exp_y [32];

  monpro_operand_feeder_if #(.DATA_WIDTH(128)) bus ();

  monpro_operand_feeder #(
    .DATA_WIDTH (128),
    .NUM_WORDS  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic sel, input logic [4:0] addr, input logic [127:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Entered in the cycle right after go was sampled; leaves in the ready cycle.
  task automatic check_stream(input string name, input bit mid_write, input bit mid_go);
    check({name, " start"}, bus.mp_start, 1);
    check({name, " start_inp"}, bus.mp_inp, 0);
    check({name, " start_ready"}, bus.ready, 0);
    step();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("%s x[%0d]", name, k), bus.mp_inp, exp_x[k]);
      check($sformatf("%s x_start[%0d]", name, k), bus.mp_start, 0);
      if (mid_write && k == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b1;
        bus.wr_addr = 5'd5;
        bus.wr_data = '1;
      end else begin
        bus.wr_en = 1'b0;
      end
      if (mid_go && k == 10) bus.go = 1'b1;
      if (mid_go && k == 11) bus.go = 1'b0;
      step();
    end
    bus.wr_en = 1'b0;
    check({name, " gap"}, bus.mp_inp, 0);
    step();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("%s y[%0d]", name, k), bus.mp_inp, exp_y[k]);
      check($sformatf("%s y_done[%0d]", name, k), bus.done, 0);
      step();
    end
    check({name, " done"}, bus.done, 1);
    check({name, " fin_inp"}, bus.mp_inp, 0);
    check({name, " fin_ready"}, bus.ready, 0);
    step();
    check({name, " ready"}, bus.ready, 1);
    check({name, " idle_done"}, bus.done, 0);
    check({name, " idle_inp"}, bus.mp_inp, 0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.go      = 1'b0;
    bus.square  = 1'b0;
    step();
    step();
    check("rst ready", bus.ready, 1);
    check("rst done", bus.done, 0);
    check("rst start", bus.mp_start, 0);
    check("rst inp", bus.mp_inp, 0);
    reset = 1'b0;

    // Idle write must not disturb the MonPro pins.
    write_word(1'b0, 5'd3, 128'h55);
    check("idle_wr start", bus.mp_start, 0);
    check("idle_wr inp", bus.mp_inp, 0);
    check("idle_wr ready", bus.ready, 1);
    step();
    check("idle_wr start2", bus.mp_start, 0);
    check("idle_wr inp2", bus.mp_inp, 0);

    for (int k = 0; k < 32; k++) begin
      write_word(1'b0, 5'(k), 128'h1000 + 128'(k));
      write_word(1'b1, 5'(k), 128'h2000 + 128'(k));
      exp_x[k] = 128'h1000 + 128'(k);
      exp_y[k] = 128'h2000 + 128'(k);
    end

    // Nominal stream.
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    check_stream("nominal", 1'b0, 1'b0);

    // Squaring: y phase carries x.
    bus.go     = 1'b1;
    bus.square = 1'b1;
    step();
    bus.go     = 1'b0;
    bus.square = 1'b0;
    for (int k = 0; k < 32; k++) exp_y[k] = 128'h1000 + 128'(k);
    check_stream("square", 1'b0, 1'b0);

    // Locked buffers: y[5] write and a second go during SEND_X are dropped.
    for (int k = 0; k < 32; k++) exp_y[k] = 128'h2000 + 128'(k);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    check_stream("locked", 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("locked extra_done[%0d]", k), bus.done, 0);
      check($sformatf("locked extra_start[%0d]", k), bus.mp_start, 0);
      step();
    end

    // Reset mid-stream at N+20.
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    for (int k = 0; k < 19; k++) step();
    check("abort pre_inp", bus.mp_inp, exp_x[18]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort inp", bus.mp_inp, 0);
    check("abort ready", bus.ready, 1);
    check("abort start", bus.mp_start, 0);
    check("abort done", bus.done, 0);
    for (int k = 0; k < 70; k++) begin
      check($sformatf("abort no_done[%0d]", k), bus.done, 0);
      step();
    end
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    check_stream("post_abort", 1'b0, 1'b0);

    // Same-cycle write and go: new x[0] appears in the stream.
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 128'hABC;
    bus.go      = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.go    = 1'b0;
    exp_x[0]  = 128'hABC;
    check_stream("wr_go", 1'b0, 1'b0);

    // Back-to-back: go held high relaunches on the first ready cycle.
    bus.go = 1'b1;
    step();
    check_stream("b2b_first", 1'b0, 1'b0);
    step();
    bus.go = 1'b0;
    check_stream("b2b_second", 1'b0, 1'b0);
    step();
    check("final start", bus.mp_start, 0);
    check("final ready", bus.ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
